// File: rtl/id_pkg.sv
// Shared MIPS32 decode constants and the predecode record stored with every
// issue-queue entry.
package id_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;

    localparam logic [5:0] F_JR      = 6'h08;
    localparam logic [5:0] F_JALR    = 6'h09;
    localparam logic [5:0] F_SYSCALL = 6'h0C;
    localparam logic [5:0] F_BREAK   = 6'h0D;
    localparam logic [5:0] F_MTHI    = 6'h11;
    localparam logic [5:0] F_MTLO    = 6'h13;
    localparam logic [5:0] F_MULT    = 6'h18;
    localparam logic [5:0] F_MULTU   = 6'h19;
    localparam logic [5:0] F_DIV     = 6'h1A;
    localparam logic [5:0] F_DIVU    = 6'h1B;

    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;
    localparam logic [4:0] RS_MF     = 5'h00;
    localparam logic [4:0] REG_RA    = 5'd31;

    typedef struct packed {
        logic       wren;
        logic [4:0] waddr;
        logic       isload;
        logic       isbranch;
    } pd_t;

    localparam int unsigned PD_W = $bits(pd_t);

    function automatic logic is_load_op(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

endpackage

// File: rtl/id_issue_queue_if.sv
// Fetch-to-queue and queue-to-EX signal bundle; slave is the queue side.
interface id_issue_queue_if #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned INST_W = 32,
    parameter int unsigned CNT_W  = 3
);
    logic              flush_i;
    logic              if_valid_i;
    logic [PC_W-1:0]   if_pc_i;
    logic [INST_W-1:0] if_inst_i;
    logic              if_inslot_i;
    logic              if_ready_o;
    logic              ex_ready_i;
    logic              id_valid_o;
    logic [PC_W-1:0]   id_pc_o;
    logic [INST_W-1:0] id_inst_o;
    logic              id_inslot_o;
    logic              id_wren_o;
    logic [4:0]        id_waddr_o;
    logic              id_isload_o;
    logic              id_isbranch_o;
    logic [CNT_W-1:0]  id_count_o;

    modport master (
        output flush_i, if_valid_i, if_pc_i, if_inst_i, if_inslot_i, ex_ready_i,
        input  if_ready_o, id_valid_o, id_pc_o, id_inst_o, id_inslot_o,
               id_wren_o, id_waddr_o, id_isload_o, id_isbranch_o, id_count_o
    );

    modport slave (
        input  flush_i, if_valid_i, if_pc_i, if_inst_i, if_inslot_i, ex_ready_i,
        output if_ready_o, id_valid_o, id_pc_o, id_inst_o, id_inslot_o,
               id_wren_o, id_waddr_o, id_isload_o, id_isbranch_o, id_count_o
    );
endinterface

// File: rtl/id_predecode.sv
// Combinational MIPS32 predecode: GPR write target, load and branch/jump flags.
module id_predecode
    import id_pkg::*;
(
    input  logic [31:0] inst,
    output pd_t         pd
);
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [5:0] funct;
    logic       wr;
    logic [4:0] wa;
    logic       unused_bits;

    assign op          = inst[31:26];
    assign rs          = inst[25:21];
    assign rt          = inst[20:16];
    assign rd          = inst[15:11];
    assign funct       = inst[5:0];
    assign unused_bits = ^inst[10:6];

    always_comb begin
        wr = 1'b0;
        wa = 5'd0;
        pd = '0;

        if (op == OP_JAL) begin
            wr = 1'b1;
            wa = REG_RA;
        end else if (op == OP_REGIMM) begin
            if ((rt == RT_BLTZAL) || (rt == RT_BGEZAL)) begin
                wr = 1'b1;
                wa = REG_RA;
            end
        end else if (((op >= OP_ADDI) && (op <= OP_LUI)) || is_load_op(op) ||
                     ((op == OP_COP0) && (rs == RS_MF))) begin
            wr = 1'b1;
            wa = rt;
        end else if (op == OP_SPECIAL) begin
            // HI/LO writers and traps never touch the GPR file
            unique case (funct)
                F_JR, F_MTHI, F_MTLO, F_MULT, F_MULTU,
                F_DIV, F_DIVU, F_SYSCALL, F_BREAK: wr = 1'b0;
                default: begin
                    wr = 1'b1;
                    wa = rd;
                end
            endcase
        end

        pd.wren     = wr && (wa != 5'd0);
        pd.waddr    = wr ? wa : 5'd0;
        pd.isload   = is_load_op(op);
        pd.isbranch = ((op >= OP_J) && (op <= OP_BGTZ)) || (op == OP_REGIMM) ||
                      ((op == OP_SPECIAL) && ((funct == F_JR) || (funct == F_JALR)));
    end
endmodule

// File: rtl/id_issue_queue.sv
// ID-stage issue FIFO: predecodes on write, issues head to EX with load-use
// interlock and optional branch/delay-slot pairing.
module id_issue_queue
    import id_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PC_W      = 32,
    parameter int unsigned INST_W    = 32,
    parameter int unsigned SLOT_PAIR = 1
) (
    input  logic          clk,
    input  logic          rst,
    id_issue_queue_if.slave q
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PC_W-1:0]   pc_mem     [DEPTH];
    logic [INST_W-1:0] inst_mem   [DEPTH];
    logic              inslot_mem [DEPTH];
    logic [PD_W-1:0]   pd_mem     [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             lu_valid;
    logic [4:0]       lu_addr;

    pd_t         wr_pd;
    pd_t         head_pd;
    logic [4:0]  head_rs;
    logic [4:0]  head_rt;
    logic        hazard;
    logic        pair_wait;
    logic        ready;
    logic        valid;
    logic        push;
    logic        pop;

    id_predecode u_predecode (
        .inst (32'(q.if_inst_i)),
        .pd   (wr_pd)
    );

    assign head_pd = pd_t'(pd_mem[rd_ptr]);
    assign head_rs = inst_mem[rd_ptr][25:21];
    assign head_rt = inst_mem[rd_ptr][20:16];

    assign hazard    = lu_valid &&
                       (((head_rs != 5'd0) && (head_rs == lu_addr)) ||
                        ((head_rt != 5'd0) && (head_rt == lu_addr)));
    assign pair_wait = (SLOT_PAIR != 0) && head_pd.isbranch && (count < CNT_W'(2));
    assign ready     = count < CNT_W'(DEPTH);
    assign valid     = (count != '0) && !hazard && !pair_wait;
    assign push      = q.if_valid_i && ready && !q.flush_i;
    assign pop       = valid && q.ex_ready_i && !q.flush_i;

    // Storage is reset so the head reads as all-zero out of reset; flush leaves it alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem[i]     <= '0;
                inst_mem[i]   <= '0;
                inslot_mem[i] <= 1'b0;
                pd_mem[i]     <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]     <= q.if_pc_i;
            inst_mem[wr_ptr]   <= q.if_inst_i;
            inslot_mem[wr_ptr] <= q.if_inslot_i;
            pd_mem[wr_ptr]     <= PD_W'(wr_pd);
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (q.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Load-use tracker: remembers the last popped load until EX moves on
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_valid <= 1'b0;
            lu_addr  <= 5'd0;
        end else if (q.flush_i) begin
            lu_valid <= 1'b0;
        end else if (pop && head_pd.isload) begin
            lu_valid <= 1'b1;
            lu_addr  <= head_pd.waddr;
        end else if (q.ex_ready_i) begin
            lu_valid <= 1'b0;
        end
    end

    assign q.if_ready_o    = ready;
    assign q.id_valid_o    = valid;
    assign q.id_pc_o       = pc_mem[rd_ptr];
    assign q.id_inst_o     = inst_mem[rd_ptr];
    assign q.id_inslot_o   = inslot_mem[rd_ptr];
    assign q.id_wren_o     = head_pd.wren;
    assign q.id_waddr_o    = head_pd.waddr;
    assign q.id_isload_o   = head_pd.isload;
    assign q.id_isbranch_o = head_pd.isbranch;
    assign q.id_count_o    = count;
endmodule

// File: tb/tb_id_issue_queue.sv
// Directed bench for id_issue_queue: FIFO flow, predecode, interlock, pairing,
// flush and asynchronous reset.
module tb_id_issue_queue;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned INST_W = 32;
    localparam int unsigned CNT_W  = 3;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    id_issue_queue_if #(.PC_W(PC_W), .INST_W(INST_W), .CNT_W(CNT_W)) bus ();

    id_issue_queue #(
        .DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W), .SLOT_PAIR(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst, input logic slot);
        bus.if_valid_i  = v;
        bus.if_pc_i     = pc;
        bus.if_inst_i   = inst;
        bus.if_inslot_i = slot;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (bus.if_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.if_ready_o); end
        n_tests++; if (bus.id_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.id_valid_o); end
        n_tests++; if (bus.id_count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.id_count_o); end
        n_tests++; if (bus.id_pc_o !== 32'h0 || bus.id_inst_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got pc %h inst %h want 0", bus.id_pc_o, bus.id_inst_o); end
        n_tests++; if ({bus.id_wren_o, bus.id_waddr_o, bus.id_isload_o, bus.id_isbranch_o, bus.id_inslot_o} !== 9'd0) begin n_fail++; $display("FAIL reset_pd: got nonzero predecode outputs, want 0"); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        drive(1'b1, 32'hBFC0_0000, 32'h0022_1821, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        n_tests++; if (bus.id_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", bus.id_valid_o); end
        n_tests++; if (bus.id_pc_o !== 32'hBFC0_0000) begin n_fail++; $display("FAIL basic_pc: got %h want bfc00000", bus.id_pc_o); end
        n_tests++; if (bus.id_wren_o !== 1'b1 || bus.id_waddr_o !== 5'd3) begin n_fail++; $display("FAIL basic_wr: got wren %b waddr %0d want 1/3", bus.id_wren_o, bus.id_waddr_o); end
        n_tests++; if (bus.id_count_o !== 3'd1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", bus.id_count_o); end
        bus.ex_ready_i = 1'b1;
        step();
        bus.ex_ready_i = 1'b0;
        n_tests++; if (bus.id_count_o !== 3'd0 || bus.id_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_pop: got count %0d valid %b want 0/0", bus.id_count_o, bus.id_valid_o); end
    endtask

    task automatic test_fill_wrap();
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 32'h100 + 32'(4 * k), 32'h2400_0000 | (32'(k) << 16), 1'b0);
            step();
            n_tests++; if (bus.id_count_o !== 3'(k)) begin n_fail++; $display("FAIL fill_count%0d: got %0d want %0d", k, bus.id_count_o, k); end
        end
        n_tests++; if (bus.if_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", bus.if_ready_o); end
        bus.ex_ready_i = 1'b1;
        drive(1'b1, 32'h114, 32'h2405_0000, 1'b0);
        step();
        n_tests++; if (bus.id_count_o !== 3'd3 || bus.id_pc_o !== 32'h108) begin n_fail++; $display("FAIL full_pop: got count %0d pc %h want 3/108", bus.id_count_o, bus.id_pc_o); end
        step();
        n_tests++; if (bus.id_count_o !== 3'd3 || bus.id_pc_o !== 32'h10C) begin n_fail++; $display("FAIL pushpop1: got count %0d pc %h want 3/10c", bus.id_count_o, bus.id_pc_o); end
        drive(1'b1, 32'h118, 32'h2406_0000, 1'b0);
        step();
        n_tests++; if (bus.id_count_o !== 3'd3 || bus.id_pc_o !== 32'h110 || bus.id_waddr_o !== 5'd4) begin n_fail++; $display("FAIL pushpop2: got count %0d pc %h waddr %0d want 3/110/4", bus.id_count_o, bus.id_pc_o, bus.id_waddr_o); end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        step();
        n_tests++; if (bus.id_pc_o !== 32'h114 || bus.id_waddr_o !== 5'd5) begin n_fail++; $display("FAIL drain_k5: got pc %h waddr %0d want 114/5", bus.id_pc_o, bus.id_waddr_o); end
        step();
        n_tests++; if (bus.id_pc_o !== 32'h118 || bus.id_count_o !== 3'd1) begin n_fail++; $display("FAIL drain_k6: got pc %h count %0d want 118/1", bus.id_pc_o, bus.id_count_o); end
        step();
        n_tests++; if (bus.id_count_o !== 3'd0 || bus.id_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got count %0d valid %b want 0/0", bus.id_count_o, bus.id_valid_o); end
        bus.ex_ready_i = 1'b0;
    endtask

    task automatic test_predecode();
        logic [31:0] vi [10];
        logic [7:0]  vx [10];
        vi = '{32'hAC05_0000, 32'h0022_0018, 32'h4004_6000, 32'h3C00_0000, 32'h0431_0000,
               32'h0020_F809, 32'h9009_0000, 32'h0800_0000, 32'h0C00_0000, 32'h0420_0000};
        // {wren, waddr[4:0], isload, isbranch}
        vx = '{{1'b0, 5'd0, 2'b00}, {1'b0, 5'd0, 2'b00}, {1'b1, 5'd4, 2'b00}, {1'b0, 5'd0, 2'b00},
               {1'b1, 5'd31, 2'b01}, {1'b1, 5'd31, 2'b01}, {1'b1, 5'd9, 2'b10}, {1'b0, 5'd0, 2'b01},
               {1'b1, 5'd31, 2'b01}, {1'b0, 5'd0, 2'b01}};
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h700 + 32'(8 * i), vi[i], 1'b0);
            step();
            drive(1'b1, 32'h704 + 32'(8 * i), 32'h0, 1'b1);
            step();
            drive(1'b0, 32'h0, 32'h0, 1'b0);
            n_tests++;
            if (bus.id_valid_o !== 1'b1 ||
                {bus.id_wren_o, bus.id_waddr_o, bus.id_isload_o, bus.id_isbranch_o} !== vx[i]) begin
                n_fail++;
                $display("FAIL predecode%0d: got valid %b pd %h want 1/%h", i, bus.id_valid_o,
                         {bus.id_wren_o, bus.id_waddr_o, bus.id_isload_o, bus.id_isbranch_o}, vx[i]);
            end
            bus.ex_ready_i = 1'b1;
            repeat (2) step();
            bus.ex_ready_i = 1'b0;
            n_tests++; if (bus.id_count_o !== 3'd0) begin n_fail++; $display("FAIL predecode%0d_drain: got count %0d want 0", i, bus.id_count_o); end
        end
        step();
    endtask

    task automatic test_load_use();
        drive(1'b1, 32'h300, 32'h8C05_0000, 1'b0);
        step();
        drive(1'b1, 32'h304, 32'h00A0_3021, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        n_tests++; if (bus.id_valid_o !== 1'b1 || bus.id_isload_o !== 1'b1 || bus.id_waddr_o !== 5'd5) begin n_fail++; $display("FAIL lu_head: got valid %b isload %b waddr %0d want 1/1/5", bus.id_valid_o, bus.id_isload_o, bus.id_waddr_o); end
        bus.ex_ready_i = 1'b1;
        step();
        n_tests++; if (bus.id_valid_o !== 1'b0 || bus.id_count_o !== 3'd1 || bus.id_pc_o !== 32'h304) begin n_fail++; $display("FAIL lu_bubble: got valid %b count %0d pc %h want 0/1/304", bus.id_valid_o, bus.id_count_o, bus.id_pc_o); end
        step();
        n_tests++; if (bus.id_valid_o !== 1'b1 || bus.id_waddr_o !== 5'd6) begin n_fail++; $display("FAIL lu_issue: got valid %b waddr %0d want 1/6", bus.id_valid_o, bus.id_waddr_o); end
        step();
        bus.ex_ready_i = 1'b0;
        n_tests++; if (bus.id_count_o !== 3'd0) begin n_fail++; $display("FAIL lu_drain: got count %0d want 0", bus.id_count_o); end
    endtask

    task automatic test_slot_pair();
        bus.ex_ready_i = 1'b1;
        drive(1'b1, 32'h200, 32'h1022_0003, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        n_tests++; if (bus.id_valid_o !== 1'b0 || bus.id_count_o !== 3'd1) begin n_fail++; $display("FAIL pair_wait: got valid %b count %0d want 0/1", bus.id_valid_o, bus.id_count_o); end
        step();
        n_tests++; if (bus.id_valid_o !== 1'b0) begin n_fail++; $display("FAIL pair_hold: got valid %b want 0", bus.id_valid_o); end
        drive(1'b1, 32'h204, 32'h0022_1821, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        n_tests++; if (bus.id_valid_o !== 1'b1 || bus.id_isbranch_o !== 1'b1 || bus.id_pc_o !== 32'h200) begin n_fail++; $display("FAIL pair_branch: got valid %b isbranch %b pc %h want 1/1/200", bus.id_valid_o, bus.id_isbranch_o, bus.id_pc_o); end
        step();
        n_tests++; if (bus.id_valid_o !== 1'b1 || bus.id_inslot_o !== 1'b1 || bus.id_pc_o !== 32'h204) begin n_fail++; $display("FAIL pair_slot: got valid %b inslot %b pc %h want 1/1/204", bus.id_valid_o, bus.id_inslot_o, bus.id_pc_o); end
        step();
        bus.ex_ready_i = 1'b0;
        n_tests++; if (bus.id_count_o !== 3'd0) begin n_fail++; $display("FAIL pair_drain: got count %0d want 0", bus.id_count_o); end
    endtask

    task automatic test_flush();
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 32'h3F0 + 32'(4 * k), 32'h2400_0000 | (32'(k) << 16), 1'b0);
            step();
        end
        n_tests++; if (bus.id_count_o !== 3'd3) begin n_fail++; $display("FAIL flush_pre: got count %0d want 3", bus.id_count_o); end
        bus.flush_i = 1'b1;
        drive(1'b1, 32'h3FC, 32'h2409_0000, 1'b0);
        step();
        bus.flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        n_tests++; if (bus.id_count_o !== 3'd0 || bus.id_valid_o !== 1'b0 || bus.if_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got count %0d valid %b ready %b want 0/0/1", bus.id_count_o, bus.id_valid_o, bus.if_ready_o); end
        step();
        n_tests++; if (bus.id_count_o !== 3'd0) begin n_fail++; $display("FAIL flush_discard: got count %0d want 0", bus.id_count_o); end
        drive(1'b1, 32'h400, 32'h2408_0000, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        n_tests++; if (bus.id_pc_o !== 32'h400 || bus.id_count_o !== 3'd1 || bus.id_waddr_o !== 5'd8) begin n_fail++; $display("FAIL flush_after: got pc %h count %0d waddr %0d want 400/1/8", bus.id_pc_o, bus.id_count_o, bus.id_waddr_o); end
        bus.ex_ready_i = 1'b1;
        step();
        bus.ex_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h500, 32'h8C05_0000, 1'b0);
        step();
        drive(1'b1, 32'h504, 32'h00A0_3021, 1'b0);
        step();
        drive(1'b1, 32'h508, 32'h2407_0000, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        bus.ex_ready_i = 1'b1;
        step();
        bus.ex_ready_i = 1'b0;
        n_tests++; if (bus.id_count_o !== 3'd2 || bus.id_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_pre: got count %0d valid %b want 2/0", bus.id_count_o, bus.id_valid_o); end
        rst = 1'b1;
        #1;
        n_tests++; if (bus.id_count_o !== 3'd0 || bus.id_valid_o !== 1'b0 || bus.if_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_ctl: got count %0d valid %b ready %b want 0/0/1", bus.id_count_o, bus.id_valid_o, bus.if_ready_o); end
        n_tests++; if (bus.id_pc_o !== 32'h0 || bus.id_inst_o !== 32'h0 || bus.id_waddr_o !== 5'd0) begin n_fail++; $display("FAIL rstmid_data: got pc %h inst %h waddr %0d want 0", bus.id_pc_o, bus.id_inst_o, bus.id_waddr_o); end
        step();
        rst = 1'b0;
        drive(1'b1, 32'h600, 32'h00A0_3021, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        n_tests++; if (bus.id_valid_o !== 1'b1 || bus.id_pc_o !== 32'h600) begin n_fail++; $display("FAIL rstmid_nobubble: got valid %b pc %h want 1/600", bus.id_valid_o, bus.id_pc_o); end
        bus.ex_ready_i = 1'b1;
        step();
        bus.ex_ready_i = 1'b0;
        n_tests++; if (bus.id_count_o !== 3'd0) begin n_fail++; $display("FAIL rstmid_drain: got count %0d want 0", bus.id_count_o); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.flush_i    = 1'b0;
        bus.ex_ready_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        test_reset();
        test_basic();
        test_fill_wrap();
        test_predecode();
        test_load_use();
        test_slot_pair();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
